// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory and writeback half of the RV32I pipeline. Holds the word-addressed
// data memory, a load-latency FSM that holds a load in M for MEM_LATENCY extra
// cycles (raising StallMemM), the M->W pipeline register and the ResultW
// select mux.
//
// Parameters
//   DEPTH_WORDS  data memory size in 32-bit words (power of two)
//   MEM_LATENCY  extra stall cycles per load, 0..15 (0 = no stall)
//   INIT_FILE    name of a hex image; memory contents are undefined until
//                written
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous, active-high
//   ALUResultM   address / ALU result from M stage
//   WriteDataM   store data
//   MemWriteM    store enable
//   ResultSrcM   00 ALU, 01 load data, 10 PC+4, 11 reserved
//   RegWriteM    register write enable
//   RdM          destination register
//   PCPlus4M     link value
//   StallMemM    stall request; M inputs must stay stable while high
//   ResultW      writeback value
//   RdW          writeback destination
//   RegWriteW    writeback enable
//   ReadDataW    registered load data
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DEPTH_WORDS = 64,
    parameter int MEM_LATENCY = 2,
    parameter     INIT_FILE   = "dmem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        RegWriteM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        StallMemM,
    output logic [31:0] ResultW,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [31:0] ReadDataW
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_C = 4'(MEM_LATENCY);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             load_m;
    logic             stall;
    logic [31:0]      rd_data;

    // W-stage register, next-state and current
    logic        regwrite_d, regwrite_q;
    logic [4:0]  rd_d, rd_q;
    logic [1:0]  src_d, src_q;
    logic [31:0] alu_d, alu_q;
    logic [31:0] pc4_d, pc4_q;
    logic [31:0] rdata_d, rdata_q;

    // Byte offset bits are dropped; upper address bits beyond the array wrap.
    assign idx     = ALUResultM[IDX_W+1:2];
    assign load_m  = (ResultSrcM == 2'b01) && RegWriteM;
    // The load is released in the cycle the counter reaches the latency;
    // with zero latency the counter sits at 0 and never stalls.
    assign stall   = !reset && load_m && (cnt_q != LAT_C);
    assign rd_data = mem[idx];

    // Keeps the image-name parameter referenced.
    localparam int unused_init_file_bits = $bits(INIT_FILE);

    // Stores commit only on the edge where the instruction leaves M.
    always_ff @(posedge clk) begin
        if (!reset && MemWriteM && !stall) begin
            mem[idx] <= WriteDataM;
        end
    end

    // Load-latency FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_m && (MEM_LATENCY > 0)) begin
                        state_q <= S_WAIT;
                        cnt_q   <= 4'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == LAT_C) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // A stalled M stage feeds a bubble into W.
    always_comb begin
        regwrite_d = RegWriteM;
        rd_d       = RdM;
        src_d      = ResultSrcM;
        alu_d      = ALUResultM;
        pc4_d      = PCPlus4M;
        rdata_d    = rd_data;
        if (stall) begin
            regwrite_d = 1'b0;
            rd_d       = 5'd0;
            src_d      = 2'b00;
            alu_d      = 32'd0;
            pc4_d      = 32'd0;
            rdata_d    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            src_q      <= 2'b00;
            alu_q      <= 32'd0;
            pc4_q      <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            src_q      <= src_d;
            alu_q      <= alu_d;
            pc4_q      <= pc4_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        case (src_q)
            2'b00:   ResultW = alu_q;
            2'b01:   ResultW = rdata_q;
            2'b10:   ResultW = pc4_q;
            default: ResultW = 32'd0;
        endcase
    end

    assign StallMemM = stall;
    assign RdW       = rd_q;
    assign RegWriteW = regwrite_q;
    assign ReadDataW = rdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int N = 3;   // dut0: latency 2, dut1: latency 0, dut2: latency 3

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [N];
    logic [31:0] alu   [N];
    logic [31:0] wd    [N];
    logic [31:0] pc4   [N];
    logic        mw    [N];
    logic        rw    [N];
    logic [1:0]  rs    [N];
    logic [4:0]  rd    [N];

    logic        stall_o [N];
    logic [31:0] res_o   [N];
    logic [4:0]  rdw_o   [N];
    logic        rww_o   [N];
    logic [31:0] rdd_o   [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            mem_wb_stage #(
                .DEPTH_WORDS(64),
                .MEM_LATENCY((gi == 0) ? 2 : ((gi == 1) ? 0 : 3))
            ) u_dut (
                .clk       (clk),
                .reset     (rst[gi]),
                .ALUResultM(alu[gi]),
                .WriteDataM(wd[gi]),
                .MemWriteM (mw[gi]),
                .ResultSrcM(rs[gi]),
                .RegWriteM (rw[gi]),
                .RdM       (rd[gi]),
                .PCPlus4M  (pc4[gi]),
                .StallMemM (stall_o[gi]),
                .ResultW   (res_o[gi]),
                .RdW       (rdw_o[gi]),
                .RegWriteW (rww_o[gi]),
                .ReadDataW (rdd_o[gi])
            );
        end
    endgenerate

    // ---------------- reference model state ----------------
    logic [31:0] mmem [int];          // key = dut*1024 + word index
    bit          e_stall  [N];
    bit          e_rw     [N];
    logic [4:0]  e_rd     [N];
    logic [31:0] e_res    [N];
    logic [31:0] e_rdd    [N];
    bit          e_res_ok [N];
    bit          e_rdd_ok [N];
    bit          chk_en   [N];
    int          stall_seen [N];

    int n_vec = 0;
    int n_bad = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk32(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", name, k, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (chk_en[k]) begin
                chk32("stall", k, 32'(stall_o[k]), 32'(e_stall[k]));
                chk32("regwrite_w", k, 32'(rww_o[k]), 32'(e_rw[k]));
                chk32("rd_w", k, 32'(rdw_o[k]), 32'(e_rd[k]));
                if (e_res_ok[k]) chk32("result_w", k, res_o[k], e_res[k]);
                if (e_rdd_ok[k]) chk32("readdata_w", k, rdd_o[k], e_rdd[k]);
                if (stall_o[k] === 1'b1) stall_seen[k]++;
            end
        end
    end

    // One clock edge; afterwards update the model for every DUT from the
    // inputs it saw during that cycle.
    task automatic step();
        int          key;
        bit          known;
        logic [31:0] data;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (rst[k]) begin
                e_rw[k] = 0; e_rd[k] = 0; e_res[k] = 0; e_rdd[k] = 0;
                e_res_ok[k] = 1; e_rdd_ok[k] = 1;
            end else if (e_stall[k]) begin
                e_rw[k] = 0; e_rd[k] = 0;
                e_res_ok[k] = 0; e_rdd_ok[k] = 0;
            end else begin
                key   = k * 1024 + int'((alu[k] >> 2) % 64);
                known = mmem.exists(key);
                data  = known ? mmem[key] : 32'hx;
                e_rw[k]     = rw[k];
                e_rd[k]     = rd[k];
                e_rdd[k]    = data;
                e_rdd_ok[k] = known;
                e_res_ok[k] = 1;
                if (rs[k] == 2'd0)      e_res[k] = alu[k];
                else if (rs[k] == 2'd2) e_res[k] = pc4[k];
                else if (rs[k] == 2'd3) e_res[k] = 32'd0;
                else begin
                    e_res[k]    = data;
                    e_res_ok[k] = known;
                end
                if (mw[k]) mmem[key] = wd[k];
            end
            chk_en[k] = 1;
        end
    endtask

    task automatic idle(input int k);
        alu[k] = 0; wd[k] = 0; pc4[k] = 0; mw[k] = 0;
        rw[k] = 0; rs[k] = 0; rd[k] = 0; e_stall[k] = 0;
    endtask

    // Issue one instruction into M of dut k and hold it for as long as it
    // occupies M: a load takes latency+1 cycles, everything else one.
    task automatic op(input int k, input logic [31:0] a, input logic [31:0] w, input logic [31:0] p,
                      input logic m, input logic r, input logic [1:0] s, input logic [4:0] d);
        bit is_load;
        int n;
        is_load = (s == 2'b01) && r;
        n = is_load ? lat_of(k) + 1 : 1;
        $display("dut%0d op addr=%h wdata=%h pc4=%h we=%0d rw=%0d src=%0d rd=%0d", k, a, w, p, m, r, s, d);
        for (int i = 0; i < n; i++) begin
            alu[k] = a; wd[k] = w; pc4[k] = p; mw[k] = m;
            rw[k] = r; rs[k] = s; rd[k] = d;
            e_stall[k] = is_load && (i < lat_of(k));
            step();
        end
        idle(k);
    endtask

    initial begin
        int s0;
        for (int k = 0; k < N; k++) begin
            idle(k);
            chk_en[k] = 0;
            stall_seen[k] = 0;
            // reset held with a load presented: no stall may appear
            rst[k] = 1; alu[k] = 32'h10; rs[k] = 2'b01; rw[k] = 1; rd[k] = 5'd7;
        end
        step();
        step();
        for (int k = 0; k < N; k++) begin
            chk32("reset_stall", k, 32'(stall_o[k]), 32'd0);
            chk32("reset_result", k, res_o[k], 32'd0);
            rst[k] = 0;
            idle(k);
        end
        step();

        // store then load, latency 2
        op(0, 32'h10, 32'hDEADBEEF, 0, 1, 0, 2'b00, 0);
        s0 = stall_seen[0];
        op(0, 32'h10, 0, 0, 0, 1, 2'b01, 5);
        chk32("lat2_stall_cycles", 0, 32'(stall_seen[0] - s0), 32'd2);
        chk32("lat2_regwrite", 0, 32'(rww_o[0]), 32'd1);
        chk32("lat2_rd", 0, 32'(rdw_o[0]), 32'd5);
        chk32("lat2_result", 0, res_o[0], 32'hDEADBEEF);

        // latency 0
        op(1, 32'h10, 32'hDEADBEEF, 0, 1, 0, 2'b00, 0);
        s0 = stall_seen[1];
        op(1, 32'h10, 0, 0, 0, 1, 2'b01, 5);
        chk32("lat0_stall_cycles", 1, 32'(stall_seen[1] - s0), 32'd0);
        chk32("lat0_result", 1, res_o[1], 32'hDEADBEEF);

        // result select
        op(0, 32'h1234, 0, 32'h40, 0, 1, 2'b00, 3);
        chk32("sel_alu", 0, res_o[0], 32'h1234);
        op(0, 32'h1234, 0, 32'h40, 0, 1, 2'b10, 3);
        chk32("sel_pc4", 0, res_o[0], 32'h40);
        op(0, 32'h1234, 0, 32'h40, 0, 1, 2'b11, 3);
        chk32("sel_rsvd", 0, res_o[0], 32'h0);

        // wrap / alignment
        op(0, 32'h103, 32'hA5A5A5A5, 0, 1, 0, 2'b00, 0);
        op(0, 32'h0, 0, 0, 0, 1, 2'b01, 9);
        chk32("wrap_result", 0, res_o[0], 32'hA5A5A5A5);

        // reset in the second stall cycle of a latency-3 load
        op(2, 32'h20, 32'h11223344, 0, 1, 0, 2'b00, 0);
        alu[2] = 32'h20; rs[2] = 2'b01; rw[2] = 1; rd[2] = 6;
        e_stall[2] = 1;
        step();
        rst[2] = 1; e_stall[2] = 0;
        step();
        chk32("abort_regwrite", 2, 32'(rww_o[2]), 32'd0);
        rst[2] = 0;
        idle(2);
        step();
        chk32("abort_no_pulse", 2, 32'(rww_o[2]), 32'd0);
        s0 = stall_seen[2];
        op(2, 32'h20, 0, 0, 0, 1, 2'b01, 6);
        chk32("reload_stall_cycles", 2, 32'(stall_seen[2] - s0), 32'd3);
        chk32("reload_result", 2, res_o[2], 32'h11223344);

        // randomized traffic on every instance
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 40; i++) begin
                op(k, $urandom_range(0, 1023), $urandom, $urandom,
                   1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            end
        end
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
